barcode_entry_sequencer: RTL
============================

// Module: barcode_entry_sequencer
// PURPOSE
//  Sequences keypad entry into the 4-digit barcode shift register and hands the completed
//  barcode to the product-lookup block over a req/ack handshake. Owns the shift register's
//  enable, digit and clear inputs, tracks the digit count, enforces an inactivity timeout,
//  and reports the lookup result to the display/UI logic. Sits between the keypad scanner
//  and the barcode controller.
// PARAMETERS
//  NUM_DIGITS      4            digits per barcode; ENTER is accepted only at this count
//  TIMEOUT_CYCLES  250000000    idle cycles (5 s at 50 MHz) in ENTRY/FULL before auto-clear
//  LOOKUP_TIMEOUT  1024         max cycles REQ is held without ACK (LOOKUP_WDOG_EN only)
// PORTS
//  CLK            in   1  system clock (CLOCK_50)
//  RESET_N        in   1  asynchronous, active-low reset
//  KEY_VALID      in   1  one-cycle strobe from keypad scanner
//  KEY_CODE       in   4  0-9 digit; 4'hA CLEAR; 4'hB ENTER; 4'hC-4'hF ignored (no state change)
//  LOOKUP_ACK     in   1  lookup done; sampled only while LOOKUP_REQ=1
//  LOOKUP_HIT     in   1  product found; valid with LOOKUP_ACK
//  SR_ENABLE      out  1  one-cycle shift pulse to barcode register
//  SR_DIGIT       out  4  digit shifted in; valid while SR_ENABLE=1, else holds last value
//  SR_CLR_N       out  1  active-low one-cycle clear pulse to barcode register
//  LOOKUP_REQ     out  1  lookup request; held high until ACK
//  RESULT_VALID   out  1  lookup result present (RESULT state)
//  RESULT_HIT     out  1  lookup outcome; meaningful while RESULT_VALID=1
//  ENTRY_ERR      out  1  sticky illegal-key flag
//  DIGIT_COUNT    out  3  digits currently held (0..NUM_DIGITS)
//  BUSY           out  1  high in LOOKUP
// BEHAVIOUR
//  - All outputs registered. Reset values: SR_CLR_N=1, all other outputs 0; state IDLE.
//  - States: IDLE(count 0), ENTRY(1..N-1), FULL(N), LOOKUP, RESULT, CLR.
//  - Digit key in IDLE/ENTRY: next cycle SR_ENABLE=1, SR_DIGIT=KEY_CODE, DIGIT_COUNT+1;
//    -> ENTRY, or FULL when the count reaches N. Latency 1 clock. Clears ENTRY_ERR.
//  - Digit key in FULL, or ENTER in IDLE/ENTRY: no shift, ENTRY_ERR<=1, no state change.
//  - ENTER in FULL: LOOKUP_REQ=1 next cycle, BUSY=1 -> LOOKUP; ENTRY_ERR<=0.
//  - LOOKUP: REQ held high. On ACK sampled high: REQ=0 and RESULT_HIT<=LOOKUP_HIT at
//    the same edge; RESULT_VALID=1 -> RESULT. Digit/ENTER keys ignored.
//  - CLEAR in any state except CLR -> CLR (aborts LOOKUP: REQ drops next edge).
//    CLEAR and ACK in the same cycle: CLEAR wins, ACK discarded.
//  - RESULT: holds until ENTER or CLEAR -> CLR; digits ignored; no timeout.
//  - CLR: SR_CLR_N=0 for exactly one cycle; DIGIT_COUNT, RESULT_VALID, RESULT_HIT,
//    ENTRY_ERR <= 0 -> IDLE. Key strobes arriving in CLR are dropped.
//  - Inactivity counter: counts in ENTRY/FULL; reloads on every KEY_VALID and on state
//    entry; reaching TIMEOUT_CYCLES-1 -> CLR. A KEY_VALID in the expiry cycle wins
//    (key processed, counter reloaded).
//  - Counter widths sized by $clog2; DIGIT_COUNT never exceeds NUM_DIGITS, never wraps.
//  - Reset asserted mid-LOOKUP drops REQ immediately (async); a late ACK lands in IDLE,
//    where it is ignored.
// CONFIGURATION
//  LOOKUP_WDOG_EN defined: in LOOKUP, a counter starts at REQ rise; with no ACK after
//    LOOKUP_TIMEOUT cycles, REQ=0, RESULT_HIT=0, RESULT_VALID=1, ENTRY_ERR=1 -> RESULT.
//  Undefined: no watchdog; REQ held indefinitely until ACK or CLEAR.
// TESTING
//  1 keys 1,2,3,4 then ENTER, ACK+HIT=1 after 5 cycles -> 4 SR_ENABLE pulses with
//    SR_DIGIT 1,2,3,4, DIGIT_COUNT 4, REQ high 5 cycles, RESULT_VALID=1, RESULT_HIT=1
//  2 keys 7,8 then ENTER -> no REQ, ENTRY_ERR=1, count stays 2; then key 9 -> ENTRY_ERR=0
//  3 key 5 then idle TIMEOUT_CYCLES (bench uses 100) -> single SR_CLR_N low cycle, count 0
//  4 in LOOKUP, CLEAR with ACK in the same cycle -> REQ drops, RESULT_VALID stays 0, IDLE
//  5 key 5 then RESET_N low mid-cycle -> all outputs return to reset values with no clock
//  6 LOOKUP_WDOG_EN, LOOKUP_TIMEOUT=16, no ACK -> REQ low after 16 cycles, ENTRY_ERR=1, RESULT_HIT=0

Source files
------------

// File: rtl/barcode_entry_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : barcode_entry_sequencer
// Brief    : Keypad-to-barcode entry sequencer with a req/ack product lookup.
//            Optional lookup watchdog enabled by defining LOOKUP_WDOG_EN.
// Revision : 1.0 - initial release
// ============================================================================
module barcode_entry_sequencer #(
    parameter int NUM_DIGITS     = 4,
    parameter int TIMEOUT_CYCLES = 250000000,
    parameter int LOOKUP_TIMEOUT = 1024
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              key_valid,
    input  logic [3:0]                        key_code,
    input  logic                              lookup_ack,
    input  logic                              lookup_hit,
    output logic                              sr_enable,
    output logic [3:0]                        sr_digit,
    output logic                              sr_clr_n,
    output logic                              lookup_req,
    output logic                              result_valid,
    output logic                              result_hit,
    output logic                              entry_err,
    output logic [$clog2(NUM_DIGITS+1)-1:0]   digit_count,
    output logic                              busy
);

    localparam int CW = $clog2(NUM_DIGITS + 1);
    localparam int IW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [IW-1:0] c_idle_last = IW'(TIMEOUT_CYCLES - 1);
    localparam logic [CW-1:0] c_full_cnt  = CW'(NUM_DIGITS);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_ENTRY  = 3'd1,
        S_FULL   = 3'd2,
        S_LOOKUP = 3'd3,
        S_RESULT = 3'd4,
        S_CLR    = 3'd5
    } state_t;

    state_t          r_state, w_state_nxt;
    logic            r_sr_enable, w_sr_enable_nxt;
    logic [3:0]      r_sr_digit, w_sr_digit_nxt;
    logic            r_sr_clr_n, w_sr_clr_n_nxt;
    logic            r_req, w_req_nxt;
    logic            r_rv, w_rv_nxt;
    logic            r_hit, w_hit_nxt;
    logic            r_err, w_err_nxt;
    logic [CW-1:0]   r_cnt, w_cnt_nxt;
    logic            r_busy, w_busy_nxt;
    logic [IW-1:0]   r_idle_cnt;
    logic            w_go_clr;

    logic w_is_digit, w_is_clear, w_is_enter, w_idle_expire, w_wdog_expire;
    logic [CW-1:0] w_cnt_inc;

    assign w_is_digit = (key_code <= 4'd9);
    assign w_is_clear = (key_code == 4'hA);
    assign w_is_enter = (key_code == 4'hB);
    assign w_cnt_inc  = r_cnt + CW'(1);
    assign w_idle_expire = ((r_state == S_ENTRY) || (r_state == S_FULL)) &&
                           (r_idle_cnt == c_idle_last);

`ifdef LOOKUP_WDOG_EN
    localparam int WW = (LOOKUP_TIMEOUT > 2) ? $clog2(LOOKUP_TIMEOUT) : 1;
    localparam logic [WW-1:0] c_wdog_last = WW'(LOOKUP_TIMEOUT - 1);
    logic [WW-1:0] r_wdog_cnt;

    // Counts from the edge that raised REQ; cleared whenever LOOKUP is left.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_wdog_cnt <= '0;
        else if ((r_state == S_LOOKUP) && (w_state_nxt == S_LOOKUP))
            r_wdog_cnt <= r_wdog_cnt + WW'(1);
        else
            r_wdog_cnt <= '0;
    end

    assign w_wdog_expire = (r_state == S_LOOKUP) && (r_wdog_cnt == c_wdog_last);
`else
    logic w_unused_wdog;
    assign w_unused_wdog = (LOOKUP_TIMEOUT > 0);
    assign w_wdog_expire = 1'b0;
`endif

    always_comb begin
        w_state_nxt     = r_state;
        w_sr_enable_nxt = 1'b0;
        w_sr_digit_nxt  = r_sr_digit;
        w_sr_clr_n_nxt  = 1'b1;
        w_req_nxt       = r_req;
        w_rv_nxt        = r_rv;
        w_hit_nxt       = r_hit;
        w_err_nxt       = r_err;
        w_cnt_nxt       = r_cnt;
        w_busy_nxt      = r_busy;
        w_go_clr        = 1'b0;

        case (r_state)
            S_IDLE, S_ENTRY: begin
                if (key_valid) begin
                    if (w_is_digit) begin
                        w_sr_enable_nxt = 1'b1;
                        w_sr_digit_nxt  = key_code;
                        w_cnt_nxt       = w_cnt_inc;
                        w_err_nxt       = 1'b0;
                        w_state_nxt     = (w_cnt_inc == c_full_cnt) ? S_FULL : S_ENTRY;
                    end else if (w_is_enter) begin
                        w_err_nxt = 1'b1;
                    end
                end else if (w_idle_expire) begin
                    w_go_clr = 1'b1;
                end
            end
            S_FULL: begin
                if (key_valid) begin
                    if (w_is_digit) begin
                        w_err_nxt = 1'b1;
                    end else if (w_is_enter) begin
                        w_req_nxt   = 1'b1;
                        w_busy_nxt  = 1'b1;
                        w_err_nxt   = 1'b0;
                        w_state_nxt = S_LOOKUP;
                    end
                end else if (w_idle_expire) begin
                    w_go_clr = 1'b1;
                end
            end
            S_LOOKUP: begin
                if (lookup_ack) begin
                    w_req_nxt   = 1'b0;
                    w_busy_nxt  = 1'b0;
                    w_hit_nxt   = lookup_hit;
                    w_rv_nxt    = 1'b1;
                    w_state_nxt = S_RESULT;
                end else if (w_wdog_expire) begin
                    w_req_nxt   = 1'b0;
                    w_busy_nxt  = 1'b0;
                    w_hit_nxt   = 1'b0;
                    w_rv_nxt    = 1'b1;
                    w_err_nxt   = 1'b1;
                    w_state_nxt = S_RESULT;
                end
            end
            S_RESULT: begin
                if (key_valid && w_is_enter)
                    w_go_clr = 1'b1;
            end
            S_CLR: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase

        // CLEAR overrides everything else, including an ACK in the same cycle.
        if (key_valid && w_is_clear && (r_state != S_CLR))
            w_go_clr = 1'b1;

        if (w_go_clr) begin
            w_state_nxt     = S_CLR;
            w_sr_enable_nxt = 1'b0;
            w_sr_clr_n_nxt  = 1'b0;
            w_req_nxt       = 1'b0;
            w_busy_nxt      = 1'b0;
            w_rv_nxt        = 1'b0;
            w_hit_nxt       = 1'b0;
            w_err_nxt       = 1'b0;
            w_cnt_nxt       = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_sr_enable <= 1'b0;
            r_sr_digit  <= 4'h0;
            r_sr_clr_n  <= 1'b1;
            r_req       <= 1'b0;
            r_rv        <= 1'b0;
            r_hit       <= 1'b0;
            r_err       <= 1'b0;
            r_cnt       <= '0;
            r_busy      <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_sr_enable <= w_sr_enable_nxt;
            r_sr_digit  <= w_sr_digit_nxt;
            r_sr_clr_n  <= w_sr_clr_n_nxt;
            r_req       <= w_req_nxt;
            r_rv        <= w_rv_nxt;
            r_hit       <= w_hit_nxt;
            r_err       <= w_err_nxt;
            r_cnt       <= w_cnt_nxt;
            r_busy      <= w_busy_nxt;
        end
    end

    // Any key strobe or leaving ENTRY/FULL restarts the inactivity window.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_idle_cnt <= '0;
        else if (key_valid || (w_state_nxt != r_state) ||
                 !((r_state == S_ENTRY) || (r_state == S_FULL)))
            r_idle_cnt <= '0;
        else
            r_idle_cnt <= r_idle_cnt + IW'(1);
    end

    assign sr_enable    = r_sr_enable;
    assign sr_digit     = r_sr_digit;
    assign sr_clr_n     = r_sr_clr_n;
    assign lookup_req   = r_req;
    assign result_valid = r_rv;
    assign result_hit   = r_hit;
    assign entry_err    = r_err;
    assign digit_count  = r_cnt;
    assign busy         = r_busy;

endmodule
`default_nettype wire
